// File: rtl/key_debouncer.sv
// Two-key debouncer: 2-flop synchronizer, per-key confirm FSM, level and one-cycle press/release pulses.
// Define KEY_AUTOREPEAT_EN to add auto-repeat press pulses while a key is held.
module key_debouncer #(
   parameter int STABLE_CYCLES = 50000,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic       clk_50MHZ,
   input  logic       rst_i,
   input  logic [1:0] KEY_i,
   output logic [1:0] key_level_o,
   output logic [1:0] key_press_o,
   output logic [1:0] key_release_o
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   // The entry sample counts as the first disagreement, so the flip happens at count STABLE_CYCLES-2.
   localparam logic [CW-1:0] C_LAST = CW'(STABLE_CYCLES - 2);
   localparam logic [CW-1:0] C_MAX  = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   localparam logic [1:0] S_RELEASED     = 2'd0;
   localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] S_PRESSED      = 2'd2;
   localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

`ifdef KEY_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] C_REP_DELAY  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] C_REP_PERIOD = RW'(REPEAT_PERIOD - 1);
   localparam logic [RW-1:0] C_REP_ONE    = RW'(1);
`endif

   logic [1:0] r_sync1;
   logic [1:0] r_sync2;

   always_ff @(posedge clk_50MHZ or posedge rst_i) begin
      if (rst_i) begin
         r_sync1 <= 2'b11;
         r_sync2 <= 2'b11;
      end else begin
         r_sync1 <= KEY_i;
         r_sync2 <= r_sync1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_key
         logic [1:0]    r_state;
         logic [1:0]    w_state_next;
         logic [CW-1:0] r_cnt;
         logic [CW-1:0] w_cnt_next;
         logic          w_pressed;
         logic          w_accept_press;
         logic          w_accept_release;
         logic          w_press_pulse;
         logic          r_level;
         logic          r_press;
         logic          r_release;

         assign w_pressed = ~r_sync2[gi];

         always_comb begin
            w_state_next     = r_state;
            w_cnt_next       = r_cnt;
            w_accept_press   = 1'b0;
            w_accept_release = 1'b0;
            case (r_state)
               S_RELEASED: begin
                  if (w_pressed) begin
                     w_state_next = S_PRESS_WAIT;
                     w_cnt_next   = '0;
                  end
               end
               S_PRESS_WAIT: begin
                  if (!w_pressed) begin
                     w_state_next = S_RELEASED;
                     w_cnt_next   = '0;
                  end else if (r_cnt == C_LAST) begin
                     w_state_next   = S_PRESSED;
                     w_cnt_next     = '0;
                     w_accept_press = 1'b1;
                  end else if (r_cnt != C_MAX) begin
                     w_cnt_next = r_cnt + C_ONE;
                  end
               end
               S_PRESSED: begin
                  if (!w_pressed) begin
                     w_state_next = S_RELEASE_WAIT;
                     w_cnt_next   = '0;
                  end
               end
               S_RELEASE_WAIT: begin
                  if (w_pressed) begin
                     w_state_next = S_PRESSED;
                     w_cnt_next   = '0;
                  end else if (r_cnt == C_LAST) begin
                     w_state_next     = S_RELEASED;
                     w_cnt_next       = '0;
                     w_accept_release = 1'b1;
                  end else if (r_cnt != C_MAX) begin
                     w_cnt_next = r_cnt + C_ONE;
                  end
               end
               default: begin
                  w_state_next = S_RELEASED;
                  w_cnt_next   = '0;
               end
            endcase
         end

`ifdef KEY_AUTOREPEAT_EN
         logic [RW-1:0] r_rep;
         logic          w_holding;
         logic          w_rep_pulse;

         // Repeat timer runs while the accepted state is pressed, but not on the release edge itself.
         assign w_holding   = ((r_state == S_PRESSED) || (r_state == S_RELEASE_WAIT)) && !w_accept_release;
         assign w_rep_pulse = w_holding && (r_rep == '0);

         always_ff @(posedge clk_50MHZ or posedge rst_i) begin
            if (rst_i) begin
               r_rep <= '0;
            end else if (w_accept_press) begin
               r_rep <= C_REP_DELAY;
            end else if (!w_holding) begin
               r_rep <= '0;
            end else if (r_rep == '0) begin
               r_rep <= C_REP_PERIOD;
            end else begin
               r_rep <= r_rep - C_REP_ONE;
            end
         end

         assign w_press_pulse = w_accept_press | w_rep_pulse;
`else
         assign w_press_pulse = w_accept_press;
`endif

         always_ff @(posedge clk_50MHZ or posedge rst_i) begin
            if (rst_i) begin
               r_state   <= S_RELEASED;
               r_cnt     <= '0;
               r_level   <= 1'b0;
               r_press   <= 1'b0;
               r_release <= 1'b0;
            end else begin
               r_state   <= w_state_next;
               r_cnt     <= w_cnt_next;
               r_level   <= (w_state_next == S_PRESSED) || (w_state_next == S_RELEASE_WAIT);
               r_press   <= w_press_pulse;
               r_release <= w_accept_release;
            end
         end

         assign key_level_o[gi]   = r_level;
         assign key_press_o[gi]   = r_press;
         assign key_release_o[gi] = r_release;
      end
   endgenerate

endmodule

// File: tb/tb_key_debouncer.sv
// Randomized scoreboard bench for key_debouncer against a sample-window reference model.
module tb_key_debouncer;

   localparam int SC = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] key = 2'b11;
   logic [1:0] lvl;
   logic [1:0] prs;
   logic [1:0] rel;

   always #5 clk = ~clk;

   key_debouncer #(
      .STABLE_CYCLES(SC),
      .REPEAT_DELAY (RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk_50MHZ    (clk),
      .rst_i        (rst),
      .KEY_i        (key),
      .key_level_o  (lvl),
      .key_press_o  (prs),
      .key_release_o(rel)
   );

   // Expected outputs packed as {level, press, release}.
   logic [5:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input logic [5:0] want, input string nm);
      logic [5:0] got;
      got = {lvl, prs, rel};
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         if (n_bad <= 25)
            $display("FAIL %s t=%0t: got level=%b press=%b release=%b, expected level=%b press=%b release=%b",
                     nm, $time, got[5:4], got[3:2], got[1:0], want[5:4], want[3:2], want[1:0]);
      end
   endtask

   // Reference model: a key's accepted state flips when the last SC synchronized samples all differ from it.
   initial begin
      logic [1:0] hist[$];
      logic [1:0] samp[$];
      logic [1:0] acc;
      logic [1:0] s;
      logic [1:0] e_prs;
      logic [1:0] e_rel;
      int         edge_n;
      int         press_edge[2];
      int         el;
      bit         all_diff;
      acc = 2'b00;
      edge_n = 0;
      press_edge[0] = 0;
      press_edge[1] = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            hist.delete();
            hist.push_back(2'b11);
            hist.push_back(2'b11);
            samp.delete();
            acc = 2'b00;
            edge_n = 0;
         end else begin
            edge_n++;
            s = ~hist[hist.size() - 2];
            hist.push_back(key);
            while (hist.size() > 3) void'(hist.pop_front());
            samp.push_back(s);
            while (samp.size() > SC) void'(samp.pop_front());
            e_prs = 2'b00;
            e_rel = 2'b00;
            for (int k = 0; k < 2; k++) begin
               all_diff = (samp.size() == SC);
               for (int i = 0; i < samp.size(); i++)
                  if (samp[i][k] == acc[k]) all_diff = 1'b0;
               if (all_diff) begin
                  acc[k] = ~acc[k];
                  if (acc[k]) begin
                     e_prs[k] = 1'b1;
                     press_edge[k] = edge_n;
                  end else begin
                     e_rel[k] = 1'b1;
                  end
               end
`ifdef KEY_AUTOREPEAT_EN
               else if (acc[k]) begin
                  el = edge_n - press_edge[k];
                  if (el == RD || (el > RD && ((el - RD) % RP) == 0)) e_prs[k] = 1'b1;
               end
`endif
            end
            exp_q.push_back({acc, e_prs, e_rel});
         end
      end
   end

   // Monitor: one scoreboard comparison per clock, sampled just after the active edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            chk(6'b0, "reset_outputs");
         end else if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty t=%0t: got no expected entry, required one per cycle", $time);
         end else begin
            chk(exp_q.pop_front(), "cycle");
         end
         if ((prs | rel) != 2'b00)
            $display("t=%0t event press=%b release=%b level=%b", $time, prs, rel, lvl);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      tick(3);
      rst = 1'b0;
      tick(10);

      // Key 0 press: pulse exactly six edges after the change.
      key = 2'b10;
      repeat (5) @(posedge clk);
      #1 chk(6'b00_00_00, "press_edge5");
      @(posedge clk);
      #1 chk(6'b01_01_00, "press_edge6");
      @(negedge clk);
      tick(40);
      key = 2'b11;
      tick(20);

      // Short key 1 glitch.
      key = 2'b01;
      tick(3);
      key = 2'b11;
      tick(15);

      // Both keys together.
      key = 2'b00;
      tick(20);
      key = 2'b11;
      tick(20);

      // Reset in the middle of a press, key kept held.
      key = 2'b10;
      tick(2);
      rst = 1'b1;
      #1 chk(6'b0, "reset_immediate");
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1 chk(6'b01_01_00, "press_after_reset");
      @(negedge clk);
      key = 2'b11;
      tick(20);

      // Long hold for auto-repeat timing.
      key = 2'b10;
      tick(30);
      key = 2'b11;
      tick(30);

      // Chatter then settle low.
      for (int i = 0; i < 5; i++) begin
         key = 2'b10;
         tick(2);
         key = 2'b11;
         tick(2);
      end
      key = 2'b10;
      tick(30);
      key = 2'b11;
      tick(20);

      // Random segments with occasional resets.
      for (int i = 0; i < 400; i++) begin
         key = 2'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            tick($urandom_range(1, 2));
            rst = 1'b0;
         end
         if ($urandom_range(0, 9) == 0) tick($urandom_range(10, 40));
         else tick($urandom_range(1, 8));
      end
      key = 2'b11;
      tick(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
